qspim_tx_packer: RTL and testbench

QSPIM_TX_PACKER -- requirements
Module: qspim_tx_packer

---
 rtl/qspim_pkg.sv | 15 +
 rtl/qspim_sfifo.sv | 69 ++++++
 rtl/qspim_tx_packer.sv | 170 +++++++++++++++++
 tb/tb_qspim_tx_packer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/qspim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qspim_pkg
// Brief    : Shared types and constants for the QSPI master TX byte packer.
// Revision : 1.0
// ============================================================================
package qspim_pkg;

    typedef logic [1:0] resid_cnt_t;

    localparam logic [7:0] c_pad_byte = 8'h00;
    localparam int         c_lanes    = 4;

endpackage
`default_nettype wire

// File: rtl/qspim_sfifo.sv
`default_nettype none
// ============================================================================
// Module   : qspim_sfifo
// Brief    : Generic synchronous FIFO, power-of-two depth, synchronous clear.
// Revision : 1.0
// ============================================================================
module qspim_sfifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int              c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full_cnt = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == c_full_cnt);
    assign o_empty   = (r_cnt == '0);
    assign o_cnt     = r_cnt;
    assign o_rdata   = r_mem[r_rptr];

    // A push into a full FIFO stays blocked even when a pop frees a slot this cycle
    assign w_do_push = i_push & ~o_full & ~i_clr;
    assign w_do_pop  = i_pop & ~o_empty & ~i_clr;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_aw'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + (c_aw + 1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_cnt <= r_cnt - (c_aw + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qspim_tx_packer.sv
`default_nettype none
// ============================================================================
// Module   : qspim_tx_packer
// Brief    : Packs byte-enabled bus writes MSB-first into 32-bit TX FIFO words.
//            Optional sticky error flags under macro QSPIM_TXP_ERRCHK_EN.
// Revision : 1.0
// ============================================================================
module qspim_tx_packer
    import qspim_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_be,
    input  logic                     wr_last,
    output logic                     wr_full,
    output logic [31:0]              txdata,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    input  logic                     err_clr,
    output logic                     ovf_err,
    output logic                     udf_err
);

    logic [23:0] r_resid;
    resid_cnt_t  r_resid_cnt;
    logic        r_defer;
    logic [31:0] r_defer_word;

    logic [7:0]  w_bytes [8];
    logic [2:0]  w_pos;
    logic [31:0] w_full_word;
    logic [31:0] w_next_resid;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [31:0] w_fifo_rdata;
    logic        w_wr_acc;
    logic        w_word_done;
    logic        w_last_push;
    logic        w_wr_push;
    logic        w_defer_set;
    logic        w_defer_push;
    logic        w_push;
    logic [31:0] w_push_data;
    logic        w_pop;

    // Residual bytes sit at the front; enabled lanes are appended in lane order.
    // Unused residual bytes are always pad, so they can be loaded unconditionally.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_bytes[i] = c_pad_byte;
        end
        for (int i = 0; i < 3; i++) begin
            w_bytes[i] = r_resid[23-8*i -: 8];
        end
        w_pos = {1'b0, r_resid_cnt};
        for (int l = 0; l < c_lanes; l++) begin
            if (wr_be[l]) begin
                w_bytes[w_pos] = wr_data[8*l +: 8];
                w_pos          = w_pos + 3'd1;
            end
        end
    end

    assign w_full_word  = {w_bytes[0], w_bytes[1], w_bytes[2], w_bytes[3]};
    assign w_next_resid = w_pos[2] ? {w_bytes[4], w_bytes[5], w_bytes[6], c_pad_byte}
                                   : {w_bytes[0], w_bytes[1], w_bytes[2], c_pad_byte};

    assign wr_full      = w_fifo_full | r_defer;
    assign w_wr_acc     = wr_en & ~wr_full & ~flush;
    assign w_word_done  = w_pos[2];
    assign w_last_push  = wr_last & (w_pos[1:0] != 2'd0);
    assign w_wr_push    = w_wr_acc & (w_word_done | w_last_push);
    assign w_defer_set  = w_wr_acc & w_word_done & w_last_push;
    assign w_defer_push = r_defer & ~w_fifo_full & ~flush;
    assign w_push       = w_wr_push | w_defer_push;
    assign w_push_data  = r_defer     ? r_defer_word :
                          w_word_done ? w_full_word  : w_next_resid;
    assign w_pop        = data_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_resid      <= {3{c_pad_byte}};
            r_resid_cnt  <= '0;
            r_defer      <= 1'b0;
            r_defer_word <= '0;
        end else if (r_defer) begin
            if (w_defer_push) begin
                r_defer <= 1'b0;
            end
        end else if (w_wr_acc) begin
            if (w_last_push) begin
                r_resid     <= {3{c_pad_byte}};
                r_resid_cnt <= '0;
            end else begin
                r_resid     <= w_next_resid[31:8];
                r_resid_cnt <= w_pos[1:0];
            end
            // Full word goes out now; the padded tail waits one cycle
            if (w_defer_set) begin
                r_defer      <= 1'b1;
                r_defer_word <= w_next_resid;
            end
        end
    end

    qspim_sfifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_cnt   (fifo_cnt)
    );

    assign data_valid = ~w_fifo_empty;
    assign txdata     = data_valid ? w_fifo_rdata : 32'h0;

`ifdef QSPIM_TXP_ERRCHK_EN
    logic r_ovf;
    logic r_udf;
    logic w_ovf_set;
    logic w_udf_set;

    assign w_ovf_set = wr_en & wr_full;
    assign w_udf_set = data_ready & ~data_valid;

    // A new error event in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_set) begin
                r_udf <= 1'b1;
            end else if (err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign ovf_err = r_ovf;
    assign udf_err = r_udf;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign ovf_err          = 1'b0;
    assign udf_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qspim_tx_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspim_tx_packer
// Brief    : Scoreboard bench for qspim_tx_packer with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_qspim_tx_packer;

`ifdef QSPIM_TXP_ERRCHK_EN
    localparam logic [31:0] c_err_exp = 32'd1;
`else
    localparam logic [31:0] c_err_exp = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_last;
    logic        wr_full;
    logic [31:0] txdata;
    logic        data_valid;
    logic        data_ready;
    logic [2:0]  fifo_cnt;
    logic        err_clr;
    logic        ovf_err;
    logic        udf_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb [$];

    qspim_tx_packer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_last    (wr_last),
        .wr_full    (wr_full),
        .txdata     (txdata),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .fifo_cnt   (fifo_cnt),
        .err_clr    (err_clr),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every consumed head word is compared with the scoreboard front
    always @(negedge clk) begin
        if (!rst && data_ready && data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%h expected=none", txdata);
            end else begin
                chk("txdata", txdata, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d, input logic [3:0] be, input logic last);
        wr_en   = 1'b1;
        wr_data = d;
        wr_be   = be;
        wr_last = last;
        tick();
        wr_en   = 1'b0;
        wr_be   = 4'b0;
        wr_last = 1'b0;
    endtask

    task automatic pop();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic wr_pop(input logic [31:0] d);
        data_ready = 1'b1;
        wr(d, 4'b1111, 1'b0);
        data_ready = 1'b0;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = '0; wr_be = '0;
        wr_last = 1'b0; data_ready = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_cnt",   32'(fifo_cnt),   32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_full",  32'(wr_full),    32'd0);
        chk("rst_txdata", txdata,         32'h0);
        chk("rst_ovf",   32'(ovf_err),    32'd0);
        chk("rst_udf",   32'(udf_err),    32'd0);
        rst = 1'b0;
        tick();

        // Four single-byte writes form one word
        wr(32'h000000AA, 4'b0001, 1'b0);
        wr(32'h000000BB, 4'b0001, 1'b0);
        wr(32'h000000CC, 4'b0001, 1'b0);
        chk("s1_valid_early", 32'(data_valid), 32'd0);
        sb.push_back(32'hAABBCCDD);
        wr(32'h000000DD, 4'b0001, 1'b0);
        chk("s1_valid", 32'(data_valid), 32'd1);
        chk("s1_cnt",   32'(fifo_cnt),   32'd1);
        pop();
        chk("s1_cnt_pop", 32'(fifo_cnt), 32'd0);

        // Non-contiguous lanes closed with wr_last
        sb.push_back(32'h11330000);
        wr(32'h00330011, 4'b0101, 1'b1);
        chk("s2_cnt", 32'(fifo_cnt), 32'd1);
        pop();

        // Completed word plus deferred padded tail
        wr(32'h00332211, 4'b0111, 1'b0);
        chk("s3_cnt_resid", 32'(fifo_cnt), 32'd0);
        sb.push_back(32'h11223344);
        sb.push_back(32'h55667700);
        wr(32'h77665544, 4'b1111, 1'b1);
        chk("s3_full_defer", 32'(wr_full),  32'd1);
        chk("s3_cnt1",       32'(fifo_cnt), 32'd1);
        tick();
        chk("s3_full_clear", 32'(wr_full),  32'd0);
        chk("s3_cnt2",       32'(fifo_cnt), 32'd2);
        pop();
        pop();

        // Fill to depth, then an overflowing write
        sb.push_back(32'hA0A1A2A3); wr(32'hA3A2A1A0, 4'b1111, 1'b0);
        sb.push_back(32'hB0B1B2B3); wr(32'hB3B2B1B0, 4'b1111, 1'b0);
        sb.push_back(32'hC0C1C2C3); wr(32'hC3C2C1C0, 4'b1111, 1'b0);
        sb.push_back(32'hD0D1D2D3); wr(32'hD3D2D1D0, 4'b1111, 1'b0);
        chk("s4_cnt_full", 32'(fifo_cnt), 32'd4);
        chk("s4_wr_full",  32'(wr_full),  32'd1);
        wr(32'hE3E2E1E0, 4'b1111, 1'b0);
        chk("s4_cnt_drop", 32'(fifo_cnt), 32'd4);
        chk("s4_ovf",      32'(ovf_err),  c_err_exp);

        // Pop with a write into the full FIFO: the write is blocked
        wr_pop(32'hF3F2F1F0);
        chk("s5_cnt3", 32'(fifo_cnt), 32'd3);
        sb.push_back(32'h04050607);
        wr(32'h07060504, 4'b1111, 1'b0);
        chk("s5_cnt4", 32'(fifo_cnt), 32'd4);
        clr_err();
        chk("s5_ovf_clr", 32'(ovf_err), 32'd0);
        repeat (4) pop();
        chk("s5_cnt_empty", 32'(fifo_cnt),   32'd0);
        chk("s5_valid0",    32'(data_valid), 32'd0);
        chk("s5_tx0",       txdata,          32'h0);
        pop();
        chk("s5_udf",     32'(udf_err),  c_err_exp);
        chk("s5_cnt_udf", 32'(fifo_cnt), 32'd0);
        clr_err();
        chk("s5_udf_clr", 32'(udf_err), 32'd0);

        // Flush with two entries and a 2-byte residual
        wr(32'h13121110, 4'b1111, 1'b0);
        wr(32'h17161514, 4'b1111, 1'b0);
        wr(32'h00002221, 4'b0011, 1'b0);
        chk("s6_cnt2", 32'(fifo_cnt), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s6_cnt0",   32'(fifo_cnt),   32'd0);
        chk("s6_valid0", 32'(data_valid), 32'd0);
        chk("s6_full0",  32'(wr_full),    32'd0);
        sb.push_back(32'h55667788);
        wr(32'h88776655, 4'b1111, 1'b0);
        chk("s6_cnt1", 32'(fifo_cnt), 32'd1);
        pop();

        // Reset in the middle of a burst discards everything
        wr(32'h1B1A1918, 4'b1111, 1'b0);
        wr(32'h00000031, 4'b0001, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s7_cnt0",   32'(fifo_cnt),   32'd0);
        chk("s7_valid0", 32'(data_valid), 32'd0);
        sb.push_back(32'h99000000);
        wr(32'h00000099, 4'b0001, 1'b1);
        chk("s7_cnt1", 32'(fifo_cnt), 32'd1);
        pop();

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
